// File: rtl/nested_select_fsm_if.sv
// nested_select_fsm_if
//   Handshake and data bundle for nested_select_fsm.
//   Input side : in_valid/in_ready carrying in_x, in_y, in_base, plus acc_clear.
//   Output side: out_valid/out_ready carrying out_data, out_sel, out_ovf.
//   busy       : status, high while a tuple is being evaluated or presented.
//   master modport drives the tuple source and result sink; slave is the block.
interface nested_select_fsm_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [WIDTH-1:0] in_base;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_x, in_y, in_base, acc_clear, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, in_base, acc_clear, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_ovf, busy
  );
endinterface

// File: rtl/nested_select_fsm.sv
// nested_select_fsm
//   Accepts one (x, y, base) tuple per transaction, selects an addend from a
//   two-level compare (x == X_CMP, then y == Y_CMP) and emits
//   BIAS + base + addend (+ accumulator when ACCUMULATE != 0).
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : nested_select_fsm_if.slave (tuple input, result output, busy)
//
//   state  | meaning
//   S_INIT | one cycle after reset, out_data held 0
//   S_IDLE | in_ready=1, waiting for a tuple, acc_clear honoured
//   S_EVAL | compare, select addend, form sum, raise out_valid
//   S_OUT  | hold result until out_ready
module nested_select_fsm #(
  parameter int          WIDTH      = 32,
  parameter int unsigned X_CMP      = 0,
  parameter int unsigned Y_CMP      = 100,
  parameter int unsigned BIAS       = 1,
  parameter int unsigned ADD_TT     = 50,
  parameter int unsigned ADD_TF     = 5,
  parameter int unsigned ADD_FT     = 60,
  parameter int unsigned ADD_FF     = 6,
  parameter int unsigned ACCUMULATE = 0
) (
  input logic                clk,
  input logic                reset,
  nested_select_fsm_if.slave bus
);

  typedef enum logic [7:0] {
    S_INIT = 8'd0,
    S_IDLE = 8'd1,
    S_EVAL = 8'd2,
    S_OUT  = 8'd3
  } state_t;

  localparam logic [WIDTH-1:0] X_CMP_W  = WIDTH'(X_CMP);
  localparam logic [WIDTH-1:0] Y_CMP_W  = WIDTH'(Y_CMP);
  localparam logic [WIDTH-1:0] BIAS_W   = WIDTH'(BIAS);
  localparam logic [WIDTH-1:0] ADD_TT_W = WIDTH'(ADD_TT);
  localparam logic [WIDTH-1:0] ADD_TF_W = WIDTH'(ADD_TF);
  localparam logic [WIDTH-1:0] ADD_FT_W = WIDTH'(ADD_FT);
  localparam logic [WIDTH-1:0] ADD_FF_W = WIDTH'(ADD_FF);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [1:0]       sel;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] acc_term;
  logic [WIDTH:0]   sum;

  // Datapath works on the captured tuple, so it is only meaningful in S_EVAL.
  always_comb begin
    sel = {(x_q == X_CMP_W), (y_q == Y_CMP_W)};
    case (sel)
      2'b11:   addend = ADD_TT_W;
      2'b10:   addend = ADD_TF_W;
      2'b01:   addend = ADD_FT_W;
      default: addend = ADD_FF_W;
    endcase
    acc_term = (ACCUMULATE != 0) ? acc_q : '0;
    // Carry beyond bit WIDTH is dropped; out_ovf reports bit WIDTH only.
    sum = {1'b0, BIAS_W} + {1'b0, base_q} + {1'b0, addend} + {1'b0, acc_term};
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;

    case (state_q)
      S_INIT: begin
        out_data_d = '0;
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_IDLE: begin
        // Clear lands before the capture, so a same-cycle tuple sees acc = 0.
        if (bus.acc_clear) acc_d = '0;
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.in_x;
          y_d        = bus.in_y;
          base_d     = bus.in_base;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_EVAL;
        end
      end
      S_EVAL: begin
        out_data_d  = sum[WIDTH-1:0];
        out_ovf_d   = sum[WIDTH];
        out_sel_d   = sel;
        out_valid_d = 1'b1;
        if (ACCUMULATE != 0) acc_d = sum[WIDTH-1:0];
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INIT;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nested_select_fsm.sv
// tb_nested_select_fsm
//   Three instances share one stimulus stream: default (a), ACCUMULATE=1 (b)
//   and WIDTH=8 (c). Expected results come from a reference model working
//   directly on the arithmetic rules with 64-bit integers.
module tb_nested_select_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        acc_clear = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_x = '0;
  logic [31:0] in_y = '0;
  logic [31:0] in_base = '0;

  int n_checks = 0;
  int n_errors = 0;
  longint unsigned acc_b = 0;

  always #5 clk = ~clk;

  nested_select_fsm_if #(.WIDTH(32)) ifa ();
  nested_select_fsm_if #(.WIDTH(32)) ifb ();
  nested_select_fsm_if #(.WIDTH(8))  ifc ();

  assign ifa.in_valid = in_valid;   assign ifb.in_valid = in_valid;   assign ifc.in_valid = in_valid;
  assign ifa.acc_clear = acc_clear; assign ifb.acc_clear = acc_clear; assign ifc.acc_clear = acc_clear;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;
  assign ifa.in_x = in_x;           assign ifb.in_x = in_x;           assign ifc.in_x = in_x[7:0];
  assign ifa.in_y = in_y;           assign ifb.in_y = in_y;           assign ifc.in_y = in_y[7:0];
  assign ifa.in_base = in_base;     assign ifb.in_base = in_base;     assign ifc.in_base = in_base[7:0];

  nested_select_fsm #(.WIDTH(32))                  u_a (.clk(clk), .reset(reset), .bus(ifa));
  nested_select_fsm #(.WIDTH(32), .ACCUMULATE(1))  u_b (.clk(clk), .reset(reset), .bus(ifb));
  nested_select_fsm #(.WIDTH(8))                   u_c (.clk(clk), .reset(reset), .bus(ifc));

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned mask_of(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [1:0] ref_sel(input int w, input longint unsigned x, input longint unsigned y);
    longint unsigned m = mask_of(w);
    return {((x & m) == (64'd0 & m)), ((y & m) == (64'd100 & m))};
  endfunction

  // Full result at WIDTH+1 bits: low WIDTH bits are out_data, bit WIDTH is out_ovf.
  function automatic longint unsigned ref_sum(input int w, input longint unsigned x, input longint unsigned y,
                                              input longint unsigned base, input longint unsigned acc);
    longint unsigned m = mask_of(w);
    longint unsigned add;
    case (ref_sel(w, x, y))
      2'b11:   add = 50;
      2'b10:   add = 5;
      2'b01:   add = 60;
      default: add = 6;
    endcase
    return (64'd1 + (base & m) + add + (acc & m)) & mask_of(w + 1);
  endfunction

  task automatic check_status(input string tag, input logic v, input logic r, input logic b);
    check_eq({tag, "_valid_a"}, ifa.out_valid, v);
    check_eq({tag, "_valid_b"}, ifb.out_valid, v);
    check_eq({tag, "_valid_c"}, ifc.out_valid, v);
    check_eq({tag, "_ready_a"}, ifa.in_ready, r);
    check_eq({tag, "_ready_c"}, ifc.in_ready, r);
    check_eq({tag, "_busy_a"}, ifa.busy, b);
    check_eq({tag, "_busy_b"}, ifb.busy, b);
  endtask

  task automatic check_data(input string tag, input longint unsigned ea, input longint unsigned eb,
                            input longint unsigned ec);
    check_eq({tag, "_data_a"}, ifa.out_data, ea & mask_of(32));
    check_eq({tag, "_data_b"}, ifb.out_data, eb & mask_of(32));
    check_eq({tag, "_data_c"}, ifc.out_data, ec & mask_of(8));
  endtask

  // One full transaction; hold = cycles out_ready stays low while out_valid=1,
  // noise = wiggle in_valid/acc_clear while the block is not idle.
  task automatic txn(input logic [31:0] x, input logic [31:0] y, input logic [31:0] base,
                     input bit clr, input int hold, input bit noise);
    longint unsigned ea, eb, ec;
    check_eq("idle_ready_a", ifa.in_ready, 1);
    check_eq("idle_ready_b", ifb.in_ready, 1);
    in_x = x; in_y = y; in_base = base;
    in_valid = 1'b1; acc_clear = clr; out_ready = (hold == 0);
    if (clr) acc_b = 0;
    ea = ref_sum(32, x, y, base, 0);
    eb = ref_sum(32, x, y, base, acc_b);
    ec = ref_sum(8, x, y, base, 0);
    @(posedge clk); #1;
    in_valid = noise; acc_clear = noise;
    in_x = $urandom; in_y = $urandom; in_base = $urandom;
    check_status("eval", 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_status("out", 1'b1, 1'b0, 1'b1);
    check_data("out", ea, eb, ec);
    check_eq("sel_a", ifa.out_sel, ref_sel(32, x, y));
    check_eq("sel_c", ifc.out_sel, ref_sel(8, x, y));
    check_eq("ovf_a", ifa.out_ovf, (ea >> 32) & 1);
    check_eq("ovf_b", ifb.out_ovf, (eb >> 32) & 1);
    check_eq("ovf_c", ifc.out_ovf, (ec >> 8) & 1);
    acc_b = eb & mask_of(32);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_status("hold", 1'b1, 1'b0, 1'b1);
      check_data("hold", ea, eb, ec);
      check_eq("hold_sel_a", ifa.out_sel, ref_sel(32, x, y));
    end
    in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check_status("done", 1'b0, 1'b1, 1'b0);
    check_data("keep", ea, eb, ec);
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_status("rst", 1'b0, 1'b0, 1'b0);
    check_data("rst", 0, 0, 0);
    check_eq("rst_sel_a", ifa.out_sel, 0);
    check_eq("rst_ovf_a", ifa.out_ovf, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_status("init", 1'b0, 1'b1, 1'b0);
    check_data("init", 0, 0, 0);

    // Directed table: the four selector cases, back-pressure, accumulation.
    txn(32'd10, 32'd20,  32'd2, 1'b0, 0, 1'b0);
    txn(32'd0,  32'd100, 32'd1, 1'b0, 0, 1'b0);
    txn(32'd0,  32'd20,  32'd1, 1'b0, 0, 1'b0);
    txn(32'd10, 32'd100, 32'd2, 1'b0, 5, 1'b1);
    txn(32'd10, 32'd20,  32'd2, 1'b1, 0, 1'b0);
    txn(32'd10, 32'd20,  32'd2, 1'b0, 0, 1'b0);
    txn(32'd10, 32'd20,  32'd2, 1'b1, 2, 1'b0);
    // Carry out of the result width.
    txn(32'd10, 32'd20,  32'd255, 1'b0, 0, 1'b0);
    txn(32'd10, 32'd20,  32'd0,   1'b0, 0, 1'b0);
    txn(32'd0,  32'd100, 32'hFFFF_FFF0, 1'b0, 1, 1'b0);

    // Reset while a result is stalled in S_OUT.
    in_x = 32'd0; in_y = 32'd100; in_base = 32'd7;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("pre_rst_valid", ifa.out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1; acc_b = 0;
    check_status("midrst", 1'b0, 1'b0, 1'b0);
    check_data("midrst", 0, 0, 0);
    @(posedge clk); #1;
    check_status("midrst_init", 1'b0, 1'b1, 1'b0);
    txn(32'd10, 32'd20, 32'd2, 1'b0, 0, 1'b0);

    // Randomized transactions biased toward compare hits and wrap-around.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] rx, ry, rb;
      rx = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      ry = ($urandom_range(0, 1) == 0) ? 32'd100 : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'hFFFF_FFFF - $urandom_range(0, 80);
        1:       rb = 32'd255 - $urandom_range(0, 80);
        default: rb = $urandom;
      endcase
      txn(rx, ry, rb, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
